mat_result_serializer: RTL and testbench
========================================

// Module: mat_result_serializer
// PURPOSE
//  Downstream stage of the 2x2 pipelined matrix multiplier. Captures each result matrix
//  {w,x,y,z} on the multiplier's done pulse into a DEPTH-entry matrix FIFO. Drains it as a
//  32-bit element stream with valid/ready backpressure, in order w,x,y,z per matrix.
//  The multiplier cannot be stalled, so this block absorbs bursts and flags loss.
// PARAMETERS
//  DEPTH    4   matrix entries in FIFO (power of 2, >=2)
//  DATA_W   32  element width; matches multiplier w/x/y/z
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         synchronous, active-high
//  done       in   1         multiplier result strobe; w,x,y,z valid this cycle
//  w,x,y,z    in   DATA_W    signed result elements (row-major C00,C01,C10,C11)
//  out_data   out  DATA_W    current element
//  out_valid  out  1         out_data valid
//  out_ready  in   1         consumer accepts when out_valid&out_ready
//  out_idx    out  2         element index 0=w 1=x 2=y 3=z
//  out_last   out  1         high with idx 3 (last element of matrix)
//  full       out  1         DEPTH entries held
//  empty      out  1         no entries held
//  overflow   out  1         sticky: a done pulse was dropped
// BEHAVIOUR
//  Reset (sync, active-high, dominates): wr/rd ptrs, count, elem index, overflow -> 0;
//   out_valid=0, out_data=0, out_idx=0, out_last=0, empty=1, full=0. Storage not cleared.
//  Write: done & ~full -> {w,x,y,z} stored at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  Accept: out_valid & out_ready. Advances elem index 0->1->2->3.
//   Accept at idx 3 pops the entry (rd_ptr++, wraps), idx->0.
//  Simultaneous write+pop same cycle: count unchanged, both ptrs advance.
//  done while full: accepted only if same cycle pops (idx 3 accepted); else dropped, overflow<=1.
//   overflow clears only on reset.
//  out_valid = ~empty (from registered count); out_data = head entry element[idx], 0 when empty.
//  Latency: done at edge N into empty FIFO -> out_valid=1, out_data=w after edge N (visible
//   next cycle). With out_ready held 1, w,x,y,z emitted on 4 consecutive cycles.
//  Throughput: 1 element/cycle; steady done every cycle overflows (4 elems/matrix).
//  out_valid stays high and out_data stable while out_ready=0 (no retraction).
//  Reset mid-matrix: partial matrix abandoned; stream restarts at idx 0 of next written entry.
//  Arithmetic: pass-through, no width change, signed values preserved bit-exact.
//  FSM (elem counter): S_W(0)->S_X(1)->S_Y(2)->S_Z(3)->S_W on accept; holds when no accept.
// CONFIGURATION
//  DROP_CNT_EN defined: adds port drop_cnt out 8; increments per dropped done,
//   saturates at 255, clears on reset. overflow still sticky.
//  Not defined: port absent; only sticky overflow reports loss.
// TESTING
//  1) Inputs a..h=1..8 to multiplier, single done w=19,x=22,y=43,z=50, out_ready=1
//     -> next 4 cycles out_data 19,22,43,50, out_idx 0..3, out_last on 50; then empty=1.
//  2) Same matrix, out_ready=0 for 5 cycles then 1 -> out_data holds 19, out_valid=1 throughout;
//     then 19,22,43,50 in order.
//  3) 4 done pulses (matrices M0..M3), out_ready=0 -> full=1 after 4th. 5th done -> dropped,
//     overflow=1; drain yields M0..M3 only (16 elements).
//  4) Full, out_ready=1 at idx 3 of M0 in same cycle as done with M4 -> no drop, overflow=0;
//     stream M1,M2,M3,M4.
//  5) Negative values w=-400,x=-1,y=32767,z=-32768 -> emitted bit-exact signed.
//  6) reset pulse after idx 1 accepted with 2 entries queued -> next cycle out_valid=0,
//     empty=1, out_idx=0, overflow=0; subsequent done streams from idx 0.
//     DROP_CNT_EN: 300 drops -> drop_cnt=255.

Source files
------------

// File: rtl/mat_result_serializer.sv
// Matrix result FIFO for the 2x2 multiplier; streams w,x,y,z per matrix with valid/ready.
// Optional macro DROP_CNT_EN adds a saturating 8-bit drop_cnt output.
module mat_result_serializer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] z,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              full,
    output logic              empty,
    output logic              overflow
`ifdef DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_W = 2'd0,
        S_X = 2'd1,
        S_Y = 2'd2,
        S_Z = 2'd3
    } elem_state_t;

    elem_state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH][4];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              accept, pop, write, drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_W;
        end else begin
            state_q <= state_d;
        end
    end

    // A done arriving while full still fits if the head matrix leaves on the same edge.
    always_comb begin
        state_d   = state_q;
        empty     = (count == '0);
        full      = (count == (AW+1)'(DEPTH));
        out_valid = ~empty;
        accept    = out_valid & out_ready;
        pop       = accept & (state_q == S_Z);
        write     = done & (~full | pop);
        drop      = done & full & ~pop;
        out_idx   = state_q;
        out_last  = out_valid & (state_q == S_Z);
        out_data  = empty ? '0 : mem[rd_ptr][state_q];
        if (accept) begin
            case (state_q)
                S_W:     state_d = S_X;
                S_X:     state_d = S_Y;
                S_Y:     state_d = S_Z;
                default: state_d = S_W;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr][0] <= w;
            mem[wr_ptr][1] <= x;
            mem[wr_ptr][2] <= y;
            mem[wr_ptr][3] <= z;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({write, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 8'd0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mat_result_serializer.sv
// Scoreboard bench for mat_result_serializer: a matrix-count model predicts flags,
// accepted matrices queue expected elements, and a negedge monitor checks the stream.
module tb_mat_result_serializer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              done;
    logic [DATA_W-1:0] w, x, y, z;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_idx;
    logic              out_last;
    logic              full;
    logic              empty;
    logic              overflow;
`ifdef DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    mat_result_serializer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .w         (w),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
`ifdef DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
    } elem_t;

    elem_t exp_q[$];

    // Reference model: how many matrices are held, where the head's element cursor is, loss flags.
    int mcount = 0;
    int midx   = 0;
    bit movf   = 1'b0;
    int mdrops = 0;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL stream_extra: got data %0h with nothing expected at %0t", out_data, $time);
            end else begin
                elem_t e;
                e = exp_q.pop_front();
                check("stream_data", out_data, e.data);
                check("stream_idx", 32'(out_idx), 32'(e.idx));
                check("stream_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic checkOutput();
        check("out_valid", 32'(out_valid), 32'(mcount > 0));
        check("empty", 32'(empty), 32'(mcount == 0));
        check("full", 32'(full), 32'(mcount == DEPTH));
        check("overflow", 32'(overflow), 32'(movf));
        check("out_idx", 32'(out_idx), 32'(midx));
        check("out_last", 32'(out_last), 32'(mcount > 0 && midx == 3));
        if (mcount == 0) begin
            check("out_data_empty", out_data, 32'd0);
        end
`ifdef DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(mdrops));
`endif
    endtask

    // Matrix packed as {w,x,y,z}; inputs are held across one rising edge, then outputs are checked.
    task automatic applyStimulus(input bit d, input logic [127:0] m, input bit rdy, input bit rst);
        bit was_full, acc, popm;
        reset     = rst;
        done      = d;
        w         = m[127:96];
        x         = m[95:64];
        y         = m[63:32];
        z         = m[31:0];
        out_ready = rdy;
        if (rst) begin
            mcount = 0;
            midx   = 0;
            movf   = 1'b0;
            mdrops = 0;
            exp_q.delete();
        end else begin
            was_full = (mcount == DEPTH);
            acc      = (mcount > 0) && rdy;
            popm     = acc && (midx == 3);
            if (acc) midx = (midx + 1) % 4;
            if (popm) mcount--;
            if (d) begin
                if (!was_full || popm) begin
                    mcount++;
                    for (int i = 0; i < 4; i++) begin
                        elem_t e;
                        e.data = m[127 - 32*i -: 32];
                        e.idx  = 2'(i);
                        e.last = (i == 3);
                        exp_q.push_back(e);
                    end
                end else begin
                    movf = 1'b1;
                    if (mdrops < 255) mdrops++;
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    function automatic logic [127:0] randMat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [127:0] m_a;
    logic [127:0] m_neg;

    initial begin
        m_a   = {32'd19, 32'd22, 32'd43, 32'd50};
        m_neg = {32'hFFFF_FE70, 32'hFFFF_FFFF, 32'h0000_7FFF, 32'hFFFF_8000};
        reset = 1'b1; done = 1'b0; w = '0; x = '0; y = '0; z = '0; out_ready = 1'b0;

        $display("[TB] reset");
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 0);

        $display("[TB] single matrix, ready held high");
        applyStimulus(1, m_a, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0);

        $display("[TB] backpressure for five cycles");
        applyStimulus(1, m_a, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0);

        $display("[TB] fill, drop fifth, drain");
        for (int i = 0; i < 5; i++) applyStimulus(1, randMat(), 0, 0);
        for (int i = 0; i < 18; i++) applyStimulus(0, '0, 1, 0);

        $display("[TB] full with pop and write on the same edge");
        applyStimulus(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, randMat(), 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(1, randMat(), 1, 0);
        for (int i = 0; i < 17; i++) applyStimulus(0, '0, 1, 0);

        $display("[TB] signed extremes");
        applyStimulus(1, m_neg, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0);

        $display("[TB] reset mid-matrix");
        applyStimulus(1, randMat(), 0, 0);
        applyStimulus(1, randMat(), 0, 0);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 1, 1);
        applyStimulus(1, randMat(), 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(99) < 35), randMat(),
                          ($urandom_range(99) < 60), ($urandom_range(199) == 0));
        end
        for (int i = 0; i < 4 * DEPTH + 8; i++) applyStimulus(0, '0, 1, 0);
        check("drain_complete", 32'(exp_q.size()), 32'd0);

`ifdef DROP_CNT_EN
        $display("[TB] drop counter saturation");
        applyStimulus(0, '0, 0, 1);
        for (int i = 0; i < DEPTH + 300; i++) applyStimulus(1, randMat(), 0, 0);
        check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        applyStimulus(0, '0, 0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
